core_seq: RTL

- Multi-cycle sequencer for the single-issue RV32I core.
- Walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives instruction-memory and data-memory request/acknowledge handshakes, the instruction-register load, PC update and register-file write enables.
- Consumes opcode, wb_reg and the ALU compare bit from the decode/ALU datapath. Detects illegal opcodes and bus timeouts, and counts retired instructions.

---
 rtl/core_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer for the single-issue RV32I core.
// Walks each instruction through fetch, decode, execute, memory and writeback,
// and drives the memory handshakes and datapath write enables. It also traps
// on illegal opcodes or stalled bus requests and counts retired instructions.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | parked; leaves only when run is high
// FETCH  | instruction request outstanding; IR loads on imem_ack
// DECODE | opcode legality check
// EXEC   | ALU settle cycle; route to MEM (load/store) or WB
// MEM    | data request outstanding; a store retires on dmem_ack
// WB     | register writeback, PC update, retire
// TRAP   | sticky fault; only rst leaves this state

module core_seq #(
   parameter int TIMEOUT   = 16,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [6:0]           opcode,
   input  logic                 wb_reg,
   input  logic                 cmp_true,
   output logic                 imem_req,
   input  logic                 imem_ack,
   output logic                 ir_we,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_ack,
   output logic                 rf_we,
   output logic                 wb_sel_mem,
   output logic                 pc_we,
   output logic                 br_take,
   output logic                 retire,
   output logic [CNT_WIDTH-1:0] instret,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [2:0]           state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

   // The wait timer counts down from TIMEOUT-1; reaching zero without an ack
   // is the terminal count.
   localparam int             WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit             TO_EN     = (TIMEOUT > 0);
   localparam logic [WCW-1:0] WAIT_LOAD = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t         state;
   state_t         state_nxt;
   logic [WCW-1:0] wait_cnt;
   logic           is_load;
   logic           is_store;
   logic           is_branch;
   logic           op_legal;
   logic           req_active;
   logic           ack_active;
   logic           wait_expired;
   logic [1:0]     cause_nxt;

   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);

   // Opcode legality for the RV32I base set handled by this core.
   always_comb begin
      op_legal = 1'b0;
      case (opcode)
         OP_OP, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: op_legal = 1'b1;
         default:                           op_legal = 1'b0;
      endcase
   end

   // Outstanding request and its matching ack, whichever bus is active.
   assign req_active   = (state == S_FETCH) || (state == S_MEM);
   assign ack_active   = (state == S_FETCH) ? imem_ack :
                         (state == S_MEM)   ? dmem_ack : 1'b0;
   assign wait_expired = TO_EN && req_active && !ack_active && (wait_cnt == '0);

   // Next-state selection; run is only looked at on instruction boundaries.
   always_comb begin
      state_nxt = state;
      cause_nxt = CAUSE_TIMEOUT;
      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack)          state_nxt = S_DECODE;
            else if (wait_expired) state_nxt = S_TRAP;
         end
         S_DECODE: begin
            if (op_legal) begin
               state_nxt = S_EXEC;
            end else begin
               state_nxt = S_TRAP;
               cause_nxt = CAUSE_ILLEGAL;
            end
         end
         S_EXEC: begin
            state_nxt = (is_load || is_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (dmem_ack) begin
               if (is_store) state_nxt = run ? S_FETCH : S_IDLE;
               else          state_nxt = S_WB;
            end else if (wait_expired) begin
               state_nxt = S_TRAP;
            end
         end
         S_WB: begin
            state_nxt = run ? S_FETCH : S_IDLE;
         end
         S_TRAP: begin
            state_nxt = S_TRAP;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State register, bus wait timer and the sticky trap cause.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         trap_cause <= 2'b00;
      end else begin
         state <= state_nxt;
         if ((state_nxt == S_FETCH || state_nxt == S_MEM) && (state_nxt != state)) begin
            wait_cnt <= WAIT_LOAD;
         end else if (TO_EN && req_active && !ack_active && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if ((state != S_TRAP) && (state_nxt == S_TRAP)) begin
            trap_cause <= cause_nxt;
         end
      end
   end

   // Retired-instruction counter; wraps silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + 1'b1;
      end
   end

   // Handshake and enable decode from the current state and acks.
   always_comb begin
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      wb_sel_mem = 1'b0;
      pc_we      = 1'b0;
      br_take    = 1'b0;
      retire     = 1'b0;
      case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_we    = imem_ack;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            pc_we    = is_store && dmem_ack;
            retire   = is_store && dmem_ack;
         end
         S_WB: begin
            rf_we      = wb_reg && !is_store && !is_branch;
            wb_sel_mem = is_load;
            pc_we      = 1'b1;
            retire     = 1'b1;
            br_take    = is_branch && cmp_true;
         end
         default: begin
         end
      endcase
   end

   assign trap    = (state == S_TRAP);
   assign state_o = state;

endmodule
